// File: rtl/cpu_defs.sv
// cpu_defs: ALU control codes and multiplier controller state encodings.
package cpu_defs;
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, LOOP, FIX, DONE} mult_state_t;
endpackage

// File: rtl/alu_mult_ctrl_alu.sv
// ALU: combinational CPU ALU, instantiated privately by the multiplier controller.
module ALU
  import cpu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       ALUConf,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             Zero,
  output logic [WIDTH-1:0] Result
);
  logic lt;
  assign lt = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);
  always_comb begin
    Result = ALUConf == ALU_AND ? in1 & in2 :
             ALUConf == ALU_OR  ? in1 | in2 :
             ALUConf == ALU_ADD ? in1 + in2 :
             ALUConf == ALU_SUB ? in1 - in2 :
             ALUConf == ALU_SLT ? {{(WIDTH-1){1'b0}}, lt} :
             ALUConf == ALU_NOR ? ~(in1 | in2) : '0;
  end
  assign Zero = Result == '0;
endmodule

// File: rtl/alu_mult_ctrl.sv
// alu_mult_ctrl: iterative shift-add mult/multu using one private ALU add per cycle.
module alu_mult_ctrl
  import cpu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  mult_state_t state_q, state_d;
  logic sign_q, sign_d, neg_q, neg_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [5:0] cnt_q, cnt_d;
  logic [4:0] alu_conf;
  logic [WIDTH-1:0] alu_in1, alu_in2, alu_res;
  logic carry;
  ALU #(.WIDTH(WIDTH)) u_alu (
    .ALUConf(alu_conf),
    .Sign(1'b0),
    .in1(alu_in1),
    .in2(alu_in2),
    .Zero(),
    .Result(alu_res)
  );
  assign carry = alu_res < prod_q[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    alu_conf = ALU_ADD;
    alu_in1  = '0;
    alu_in2  = '0;
    case (state_q)
      IDLE: if (start) begin
        state_d = ABS_A;
        sign_d  = sign;
        a_d     = op_a;
        b_d     = op_b;
      end
      ABS_A: begin
        alu_conf = (sign_q & a_q[WIDTH-1]) ? ALU_SUB : ALU_ADD;
        alu_in2  = a_q;
        mcand_d  = alu_res;
        state_d  = ABS_B;
      end
      ABS_B: begin
        alu_conf = (sign_q & b_q[WIDTH-1]) ? ALU_SUB : ALU_ADD;
        alu_in2  = b_q;
        prod_d   = {{WIDTH{1'b0}}, alu_res};
        neg_d    = sign_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        cnt_d    = '0;
        state_d  = LOOP;
      end
      LOOP: begin
        alu_in1 = prod_q[2*WIDTH-1:WIDTH];
        alu_in2 = prod_q[0] ? mcand_q : '0;
        prod_d  = {carry, alu_res, prod_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 6'd1;
        state_d = cnt_q == 6'(ITER - 1) ? FIX : LOOP;
      end
      FIX: begin
        // hi/lo load on entry to DONE so they are valid alongside the done pulse
        prod_d       = neg_q ? ~prod_q + (2*WIDTH)'(1) : prod_q;
        {hi_d, lo_d} = prod_d;
        state_d      = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule
